imem_boot_loader: RTL and testbench

- Upstream of processor_top: fills instruction memory from a byte-serial stream and holds the processor in reset until the program is loaded and verified.
- Lets benches and FPGA builds load programs at runtime instead of via $readmemh.
- Drives the instruction-memory write port and the processor's reset input.

---
 rtl/proc_pkg.sv | 25 ++
 rtl/imem_boot_loader_assembler.sv | 38 +++
 rtl/imem_boot_loader.sv | 117 +++++++++++
 tb/tb_imem_boot_loader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the processor slice: memory geometry and the
// boot-loader state encoding.
package proc_pkg;

    localparam int DEF_ADDR_W  = 10;
    localparam int DEF_INSTR_W = 16;
    localparam int BYTE_W      = 8;

    typedef logic [2:0] state_t;

    localparam state_t ST_LEN_HI  = 3'd0;
    localparam state_t ST_LEN_LO  = 3'd1;
    localparam state_t ST_DATA_HI = 3'd2;
    localparam state_t ST_DATA_LO = 3'd3;
    localparam state_t ST_CHK     = 3'd4;
    localparam state_t ST_RELEASE = 3'd5;
    localparam state_t ST_DONE    = 3'd6;
    localparam state_t ST_ERROR   = 3'd7;

    // Byte-accepting states are encoded contiguously from LEN_HI up to CHK.
    function automatic logic accepts_bytes(input state_t s);
        return (s <= ST_CHK);
    endfunction

endpackage

// File: rtl/imem_boot_loader_assembler.sv
// Pairs HI/LO stream bytes into instruction words and keeps the running
// XOR checksum over every data byte.
module boot_byte_assembler
    import proc_pkg::*;
#(
    parameter int INSTR_W = DEF_INSTR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hi_en,
    input  logic               lo_en,
    input  logic [BYTE_W-1:0]  data,
    output logic [INSTR_W-1:0] word,
    output logic [BYTE_W-1:0]  checksum
);

    logic [BYTE_W-1:0] hi_byte;

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_byte  <= '0;
            word     <= '0;
            checksum <= '0;
        end else begin
            if (hi_en) begin
                hi_byte  <= data;
                checksum <= checksum ^ data;
            end
            // word only changes on a LO byte, so it is stable while the
            // write strobe built from the same transfer is high.
            if (lo_en) begin
                word     <= {hi_byte, data};
                checksum <= checksum ^ data;
            end
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Loads instruction memory from a byte stream (length, word pairs, XOR
// checksum) and holds the processor in reset until the image verifies.
module imem_boot_loader
    import proc_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int INSTR_W     = DEF_INSTR_W,
    parameter int RELEASE_DLY = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               imem_wr_en,
    output logic [ADDR_W-1:0]  imem_wr_addr,
    output logic [INSTR_W-1:0] imem_wr_data,
    output logic               proc_reset,
    output logic               load_done,
    output logic               load_err
);

    state_t state;
    state_t state_nxt;

    // Only the length bits that reach the address width are kept.
    logic [ADDR_W-BYTE_W-1:0] len_hi;
    logic [ADDR_W-1:0]        last_idx;
    logic [ADDR_W-1:0]        word_idx;
    logic [3:0]               rel_cnt;
    logic [BYTE_W-1:0]        checksum;

    logic xfer;
    logic last_word;
    logic hi_en;
    logic lo_en;

    assign xfer      = in_valid & in_ready;
    assign last_word = (word_idx == last_idx);
    assign hi_en     = xfer && (state == ST_DATA_HI);
    assign lo_en     = xfer && (state == ST_DATA_LO);

    boot_byte_assembler #(
        .INSTR_W (INSTR_W)
    ) u_assembler (
        .clk      (clk),
        .reset    (reset),
        .hi_en    (hi_en),
        .lo_en    (lo_en),
        .data     (in_data),
        .word     (imem_wr_data),
        .checksum (checksum)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_LEN_HI:  if (xfer) state_nxt = ST_LEN_LO;
            ST_LEN_LO:  if (xfer) state_nxt = ST_DATA_HI;
            ST_DATA_HI: if (xfer) state_nxt = ST_DATA_LO;
            ST_DATA_LO: if (xfer) state_nxt = last_word ? ST_CHK : ST_DATA_HI;
            ST_CHK: begin
                if (xfer) state_nxt = (in_data == checksum) ? ST_RELEASE : ST_ERROR;
            end
            ST_RELEASE: if (rel_cnt == 4'(RELEASE_DLY)) state_nxt = ST_DONE;
            default:    state_nxt = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_LEN_HI;
            in_ready     <= 1'b0;
            imem_wr_en   <= 1'b0;
            imem_wr_addr <= '0;
            proc_reset   <= 1'b1;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            len_hi       <= '0;
            last_idx     <= '0;
            word_idx     <= '0;
            rel_cnt      <= '0;
        end else begin
            state      <= state_nxt;
            // in_ready is registered from the next state so a terminal
            // transition closes the input on the same edge.
            in_ready   <= accepts_bytes(state_nxt);
            imem_wr_en <= 1'b0;
            proc_reset <= (state_nxt != ST_DONE);
            load_done  <= (state_nxt == ST_DONE);
            load_err   <= (state_nxt == ST_ERROR);

            case (state)
                ST_LEN_HI: if (xfer) len_hi <= in_data[ADDR_W-BYTE_W-1:0];
                ST_LEN_LO: begin
                    if (xfer) begin
                        last_idx <= {len_hi, in_data};
                        word_idx <= '0;
                    end
                end
                ST_DATA_LO: begin
                    if (xfer) begin
                        imem_wr_en   <= 1'b1;
                        imem_wr_addr <= word_idx;
                        // Holding the index on the final word keeps it from
                        // wrapping when the image fills the whole memory.
                        if (!last_word) word_idx <= word_idx + 1'b1;
                    end
                end
                ST_CHK: if (xfer) rel_cnt <= '0;
                ST_RELEASE: if (state_nxt == ST_RELEASE) rel_cnt <= rel_cnt + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: good/bad checksum, stalls, full-size
// image, mid-load reset and post-load input lockout.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        imem_wr_en;
    logic [9:0]  imem_wr_addr;
    logic [15:0] imem_wr_data;
    logic        proc_reset;
    logic        load_done;
    logic        load_err;

    imem_boot_loader #(
        .ADDR_W      (10),
        .INSTR_W     (16),
        .RELEASE_DLY (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_wr_en   (imem_wr_en),
        .imem_wr_addr (imem_wr_addr),
        .imem_wr_data (imem_wr_data),
        .proc_reset   (proc_reset),
        .load_done    (load_done),
        .load_err     (load_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [25:0] wr_q[$];
    logic [25:0] exp_q[$];
    logic [15:0] word_q[$];
    logic [7:0]  stim_q[$];

    int   checks = 0;
    int   failures = 0;
    int   chk_cyc = 0;
    int   fall_cyc = -1;
    bit   low_seen = 1'b0;
    logic prev_pr = 1'b1;

    // Write/proc_reset monitor; samples on the falling edge.
    always @(negedge clk) begin
        if (imem_wr_en) wr_q.push_back({imem_wr_addr, imem_wr_data});
        if (!proc_reset) low_seen = 1'b1;
        if (prev_pr && !proc_reset) fall_cyc = cyc;
        prev_pr = proc_reset;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        wr_q.delete();
        exp_q.delete();
        word_q.delete();
        stim_q.delete();
        low_seen = 1'b0;
        fall_cyc = -1;
    endtask

    // Builds the byte stream and expected writes from word_q.
    task automatic build_stim(input bit force_chk, input logic [7:0] chk_force);
        logic [15:0] len;
        logic [7:0]  c;
        c = 8'h00;
        len = 16'(word_q.size() - 1);
        stim_q.push_back(len[15:8]);
        stim_q.push_back(len[7:0]);
        for (int i = 0; i < word_q.size(); i++) begin
            stim_q.push_back(word_q[i][15:8]);
            stim_q.push_back(word_q[i][7:0]);
            c = c ^ word_q[i][15:8] ^ word_q[i][7:0];
            exp_q.push_back({10'(i), word_q[i]});
        end
        stim_q.push_back(force_chk ? chk_force : c);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit got;
        got = 1'b0;
        in_valid = 1'b0;
        repeat (gap) tick();
        in_data = b;
        in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            got = in_ready;
            tick();
            if (got) break;
        end
        in_valid = 1'b0;
        if (!got) check("xfer_timeout", 32'(got), 32'd1);
    endtask

    task automatic send_stim(input int gap);
        for (int i = 0; i < stim_q.size(); i++) send_byte(stim_q[i], gap);
        chk_cyc = cyc;
    endtask

    task automatic wait_end(input int limit);
        for (int t = 0; t < limit; t++) begin
            if (load_done || load_err) break;
            tick();
        end
        check("end_timeout", 32'(load_done | load_err), 32'd1);
    endtask

    task automatic compare_writes(input string tag);
        int mism;
        mism = 0;
        check({tag, "_wr_count"}, 32'(wr_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
            if (wr_q[i] !== exp_q[i]) mism++;
        check({tag, "_wr_data"}, 32'(mism), 32'd0);
    endtask

    initial begin
        int cnt_a;
        int cnt_b;
        int n0;

        // Reset values
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_wr_en", 32'(imem_wr_en), 32'd0);
        check("rst_wr_addr", 32'(imem_wr_addr), 32'd0);
        check("rst_wr_data", 32'(imem_wr_data), 32'd0);
        check("rst_proc_reset", 32'(proc_reset), 32'd1);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_load_err", 32'(load_err), 32'd0);

        // Two-word image, valid held high
        do_reset();
        word_q.push_back(16'h1234);
        word_q.push_back(16'hABCD);
        build_stim(1'b0, 8'h00);
        check("basic_chk_byte", 32'(stim_q[6]), 32'h40);
        send_stim(0);
        check("basic_pr_held_at_chk", 32'(proc_reset), 32'd1);
        wait_end(100);
        compare_writes("basic");
        check("basic_done", 32'(load_done), 32'd1);
        check("basic_err", 32'(load_err), 32'd0);
        check("basic_release_lat", 32'(fall_cyc - chk_cyc), 32'd5);
        check("basic_proc_reset", 32'(proc_reset), 32'd0);

        // Input lockout after DONE
        cnt_a = 0;
        cnt_b = 0;
        n0 = wr_q.size();
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data = 8'($urandom_range(0, 255));
            if (in_ready) cnt_a++;
            if (proc_reset) cnt_b++;
            tick();
        end
        in_valid = 1'b0;
        check("post_in_ready_hi", 32'(cnt_a), 32'd0);
        check("post_proc_reset_hi", 32'(cnt_b), 32'd0);
        check("post_writes", 32'(wr_q.size() - n0), 32'd0);
        check("post_done", 32'(load_done), 32'd1);

        // Bad checksum
        do_reset();
        word_q.push_back(16'h1234);
        word_q.push_back(16'hABCD);
        build_stim(1'b1, 8'h33);
        send_stim(0);
        wait_end(100);
        check("bad_err", 32'(load_err), 32'd1);
        check("bad_done", 32'(load_done), 32'd0);
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 50; i++) begin
            if (!proc_reset) cnt_a++;
            if (in_ready) cnt_b++;
            tick();
        end
        check("bad_proc_reset_low", 32'(cnt_a), 32'd0);
        check("bad_in_ready_hi", 32'(cnt_b), 32'd0);
        check("bad_err_sticky", 32'(load_err), 32'd1);
        compare_writes("bad");

        // Same image with three idle cycles before every byte
        do_reset();
        word_q.push_back(16'h1234);
        word_q.push_back(16'hABCD);
        build_stim(1'b0, 8'h00);
        send_stim(3);
        wait_end(100);
        compare_writes("stall");
        check("stall_done", 32'(load_done), 32'd1);
        check("stall_release_lat", 32'(fall_cyc - chk_cyc), 32'd5);

        // Full 1024-word image, word i = i
        do_reset();
        for (int i = 0; i < 1024; i++) word_q.push_back(16'(i));
        build_stim(1'b0, 8'h00);
        check("full_len_hi", 32'(stim_q[0]), 32'h03);
        check("full_len_lo", 32'(stim_q[1]), 32'hFF);
        send_stim(0);
        wait_end(100);
        compare_writes("full");
        check("full_last_write", 32'(wr_q[wr_q.size()-1]), 32'({10'd1023, 16'h03FF}));
        cnt_a = 0;
        foreach (wr_q[i]) if (wr_q[i][25:16] == 10'd0) cnt_a++;
        check("full_addr0_writes", 32'(cnt_a), 32'd1);
        check("full_done", 32'(load_done), 32'd1);

        // Reset after 3 of 5 words, then a one-word image
        do_reset();
        stim_q.push_back(8'h00);
        stim_q.push_back(8'h04);
        for (int i = 1; i <= 3; i++) begin
            stim_q.push_back(8'(i * 8'h11));
            stim_q.push_back(8'(i * 8'h11));
            exp_q.push_back({10'(i - 1), 8'(i * 8'h11), 8'(i * 8'h11)});
        end
        send_stim(0);
        compare_writes("partial");
        check("partial_in_ready", 32'(in_ready), 32'd1);
        do_reset();
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_proc_reset", 32'(proc_reset), 32'd1);
        word_q.push_back(16'hBEEF);
        build_stim(1'b0, 8'h00);
        check("midrst_chk_byte", 32'(stim_q[4]), 32'h51);
        send_stim(0);
        check("midrst_pr_never_low", 32'(low_seen), 32'd0);
        wait_end(100);
        compare_writes("midrst");
        check("midrst_done", 32'(load_done), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
